// File: rtl/serial_add_seq.sv
// Sequencer and datapath for a WIDTH-bit serial adder. It shifts two operands LSB-first
// through an external single-bit carry flop and collects the parallel sum and carry-out.
module serial_add_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_q,
  output logic             carry_d,
  output logic             sum_bit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-2:0]   sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_next;

  // Partial sum with the current bit entering at the MSB; its top WIDTH-1 bits are the next
  // shift-register value, and the whole word is the finished result on the last bit.
  assign sum_next = {sum_bit, sum_sr_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    busy     = 1'b0;
    carry_d  = 1'b0;
    sum_bit  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // Holding carry_d low here guarantees the flop presents carry 0 in the first shift cycle.
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          sum_sr_d = '0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end

      SHIFT: begin
        busy     = 1'b1;
        sum_bit  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        carry_d  = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = sum_next[WIDTH-1:1];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = sum_next;
          cout_d  = carry_d;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq wired to a behavioural carry flop.
// Expected {cout,sum} values are queued when an add is launched and popped when done pulses.
module tb_serial_add_seq;

  localparam int WIDTH = 32;
  localparam int TIMEOUT = 60;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryQ;
  logic             carry_d;
  logic             sum_bit;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int total;
  int bad;

  logic [WIDTH:0] expQ[$];

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .carry_q (carryQ),
    .carry_d (carry_d),
    .sum_bit (sum_bit),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout)
  );

  // The single-bit carry flop the sequencer feeds; shares clk and rst with the DUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) carryQ <= 1'b0;
    else     carryQ <= carry_d;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [WIDTH:0] pop_expected();
    if (expQ.size() == 0) return 'x;
    return expQ.pop_front();
  endfunction

  // Launch one add, optionally poke new operands plus start mid-shift, then wait for done.
  // Returns at the negedge where done is seen (doneCyc=-1 on timeout).
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input int pokeCycle,
                        output int doneCyc, output int busyCyc, output logic firstCarry);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    expQ.push_back(ref_add(av, bv));
    @(negedge clk);
    start = 1'b0;
    firstCarry = carryQ;
    doneCyc = -1;
    busyCyc = 0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      if (busy) busyCyc++;
      if (done) begin
        doneCyc = c;
        break;
      end
      if (c == pokeCycle) begin
        a = ~av;
        b = av ^ bv;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, sum, cout, carry_d, sum_bit} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b carry_d=%b sum_bit=%b exp all 0",
               busy, done, sum, cout, carry_d, sum_bit);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, sum, cout} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_idle got busy=%b done=%b sum=%h cout=%b exp all 0", busy, done, sum, cout);
    end
  endtask

  task automatic test_overflow();
    int dc, bc;
    logic fc;
    logic [WIDTH:0] exp;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 0, dc, bc, fc);
    total++;
    if (dc !== 33) begin bad++; $display("[TB] FAIL ovf_done_latency got=%0d exp=33", dc); end
    total++;
    if (bc !== 32) begin bad++; $display("[TB] FAIL ovf_busy_cycles got=%0d exp=32", bc); end
    exp = pop_expected();
    total++;
    if ({cout, sum} !== exp || exp !== 33'h1_0000_0000) begin
      bad++;
      $display("[TB] FAIL ovf_result got=%h exp=%h", {cout, sum}, 33'h1_0000_0000);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || {cout, sum} !== 33'h1_0000_0000) begin
      bad++;
      $display("[TB] FAIL ovf_pulse_hold got done=%b result=%h exp done=0 result=100000000", done, {cout, sum});
    end
  endtask

  task automatic test_patterns();
    int dc, bc;
    logic fc;
    logic [WIDTH:0] exp;
    run_op(32'h1234_5678, 32'h8765_4321, 0, dc, bc, fc);
    exp = pop_expected();
    total++;
    if ({cout, sum} !== exp) begin bad++; $display("[TB] FAIL pat_mixed got=%h exp=%h", {cout, sum}, exp); end
    total++;
    if (sum !== 32'h9999_9999) begin bad++; $display("[TB] FAIL pat_mixed_const got=%h exp=99999999", sum); end
    run_op(32'h8000_0000, 32'h8000_0000, 0, dc, bc, fc);
    exp = pop_expected();
    total++;
    if ({cout, sum} !== exp) begin bad++; $display("[TB] FAIL pat_msb got=%h exp=%h", {cout, sum}, exp); end
    total++;
    if (dc !== 33) begin bad++; $display("[TB] FAIL pat_msb_latency got=%0d exp=33", dc); end
  endtask

  task automatic test_back_to_back();
    int nDone;
    int lastDone;
    bit checkFirst;
    logic [WIDTH:0] exp;
    nDone = 0;
    lastDone = 0;
    checkFirst = 1'b0;
    @(negedge clk);
    a = 32'd5;
    b = 32'd7;
    start = 1'b1;
    expQ.push_back(ref_add(32'd5, 32'd7));
    for (int c = 1; c <= 4 * TIMEOUT && nDone < 3; c++) begin
      @(negedge clk);
      if (c == 1 || checkFirst) begin
        total++;
        if (busy !== 1'b1 || carryQ !== 1'b0) begin
          bad++;
          $display("[TB] FAIL b2b_first_shift cycle=%0d got busy=%b carry_q=%b exp busy=1 carry_q=0", c, busy, carryQ);
        end
        checkFirst = 1'b0;
      end
      if (done) begin
        nDone++;
        exp = pop_expected();
        total++;
        if ({cout, sum} !== exp || sum !== 32'h0000_000C) begin
          bad++;
          $display("[TB] FAIL b2b_result n=%0d got=%h exp=00000000c", nDone, {cout, sum});
        end
        total++;
        if (c - lastDone !== 33) begin
          bad++;
          $display("[TB] FAIL b2b_spacing n=%0d got=%0d exp=33", nDone, c - lastDone);
        end
        lastDone = c;
        if (nDone < 3) begin
          expQ.push_back(ref_add(32'd5, 32'd7));
          checkFirst = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    total++;
    if (nDone !== 3) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=3", nDone); end
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_stop got busy=%b exp=0", busy); end
  endtask

  task automatic test_start_ignored();
    int dc, bc;
    logic fc;
    logic [WIDTH:0] exp;
    run_op(32'hDEAD_BEEF, 32'h3141_5926, 10, dc, bc, fc);
    exp = pop_expected();
    total++;
    if ({cout, sum} !== exp) begin bad++; $display("[TB] FAIL ignore_result got=%h exp=%h", {cout, sum}, exp); end
    total++;
    if (dc !== 33) begin bad++; $display("[TB] FAIL ignore_latency got=%0d exp=33", dc); end
    total++;
    if (bc !== 32) begin bad++; $display("[TB] FAIL ignore_busy got=%0d exp=32", bc); end
  endtask

  task automatic test_async_reset();
    int dc, bc;
    int extraDone;
    logic fc;
    logic [WIDTH:0] exp;
    @(negedge clk);
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, sum, cout, carry_d, carryQ} !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset got busy=%b done=%b sum=%h cout=%b carry_d=%b carry_q=%b exp all 0",
               busy, done, sum, cout, carry_d, carryQ);
    end
    @(negedge clk);
    rst = 1'b0;
    extraDone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) extraDone++;
    end
    total++;
    if (extraDone !== 0) begin bad++; $display("[TB] FAIL async_no_done got=%0d exp=0", extraDone); end
    run_op(32'd3, 32'd4, 0, dc, bc, fc);
    exp = pop_expected();
    total++;
    if ({cout, sum} !== exp || sum !== 32'd7) begin
      bad++;
      $display("[TB] FAIL async_after got=%h exp=000000007", {cout, sum});
    end
  endtask

  task automatic test_random();
    int dc, bc;
    logic fc;
    int nOk;
    int nMissing;
    int nExtra;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH:0] exp;
    nOk = 0;
    nMissing = 0;
    nExtra = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 50 == 0) ra = 32'hFFFF_FFFF;
      if (i % 70 == 0) rb = ~ra;
      run_op(ra, rb, 0, dc, bc, fc);
      if (dc != 33) nMissing++;
      exp = pop_expected();
      total++;
      if ({cout, sum} !== exp || fc !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rand_result i=%0d a=%h b=%h got=%h exp=%h first_carry=%b",
                 i, ra, rb, {cout, sum}, exp, fc);
      end else begin
        nOk++;
      end
      @(negedge clk);
      if (done) nExtra++;
    end
    total++;
    if (nMissing !== 0 || nExtra !== 0) begin
      bad++;
      $display("[TB] FAIL rand_done_pulses got missing=%0d extra=%0d exp 0/0", nMissing, nExtra);
    end
    $display("[TB] random regression matched %0d of 1000", nOk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_overflow();
    test_patterns();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
